sd_bit_serializer: RTL and testbench



---
 rtl/sd_pkg.sv | 18 +
 rtl/sd_seq_detector_101.sv | 30 +++
 rtl/sd_bit_serializer.sv | 77 +++++++
 tb/tb_sd_bit_serializer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared state encodings and defaults for the serializer/detector family
package sd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sd_state_t;

  typedef enum logic [1:0] {
    DET_S0  = 2'd0,
    DET_S1  = 2'd1,
    DET_S10 = 2'd2
  } sd_det_state_t;

  localparam int   SD_WIDTH    = 8;
  localparam logic SD_IDLE_BIT = 1'b0;

endpackage

// File: rtl/sd_seq_detector_101.sv
// rtl/sd_seq_detector_101.sv - overlapping 101 Mealy detector, advances only on valid bits
module sd_seq_detector_101
  import sd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic detect
);

  sd_det_state_t r_state;

  assign detect = din_valid && din && (r_state == DET_S10);

  // Idle fill is not data, so history is held rather than cleared between words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DET_S0;
    end else if (din_valid) begin
      case (r_state)
        DET_S0:  r_state <= din ? DET_S1 : DET_S0;
        DET_S1:  r_state <= din ? DET_S1 : DET_S10;
        DET_S10: r_state <= din ? DET_S1 : DET_S0;
        default: r_state <= DET_S0;
      endcase
    end
  end

endmodule

// File: rtl/sd_bit_serializer.sv
// rtl/sd_bit_serializer.sv - WIDTH-bit word to serial bit stream, MSB first
// unless SD_SER_LSB_FIRST_EN is defined (then LSB first).
module sd_bit_serializer
  import sd_pkg::*;
#(
  parameter int   WIDTH    = SD_WIDTH,
  parameter logic IDLE_BIT = SD_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  sd_state_t        r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sreg;
  logic             r_dout;
  logic             r_dout_valid;

  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_next_sreg;

`ifdef SD_SER_LSB_FIRST_EN
  assign w_first_bit = load_data[0];
  assign w_next_bit  = r_sreg[1];
  assign w_next_sreg = {1'b0, r_sreg[WIDTH-1:1]};
`else
  assign w_first_bit = load_data[WIDTH-1];
  assign w_next_bit  = r_sreg[WIDTH-2];
  assign w_next_sreg = {r_sreg[WIDTH-2:0], 1'b0};
`endif

  // Ready on the final bit lets the next word follow with no bubble.
  assign load_ready = !rst && ((r_state == IDLE) || ((r_state == SHIFT) && (r_cnt == '0)));
  assign w_accept   = load_valid && load_ready;
  assign last_bit   = (r_state == SHIFT) && (r_cnt == '0);
  assign busy       = (r_state == SHIFT);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sreg       <= '0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
    end else if (w_accept) begin
      r_state      <= SHIFT;
      r_cnt        <= CW'(WIDTH - 1);
      r_sreg       <= load_data;
      r_dout       <= w_first_bit;
      r_dout_valid <= 1'b1;
    end else if (r_state == SHIFT) begin
      if (r_cnt != '0) begin
        r_cnt  <= r_cnt - 1'b1;
        r_sreg <= w_next_sreg;
        r_dout <= w_next_bit;
      end else begin
        r_state      <= IDLE;
        r_dout       <= IDLE_BIT;
        r_dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_bit_serializer.sv
// tb/tb_sd_bit_serializer.sv - directed bench for serializer feeding the 101 detector
module tb_sd_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] load_data = 8'h00;
  logic       load_valid = 1'b0;
  logic       load_ready, dout, dout_valid, last_bit, busy, detect;

  logic [1:0] l2_data = 2'b00;
  logic       l2_valid = 1'b0;
  logic       w2_ready, w2_dout, w2_valid, w2_last, w2_busy;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] m_hist = 2'b00;

  sd_bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
    .last_bit(last_bit), .busy(busy)
  );

  sd_seq_detector_101 u_det (
    .clk(clk), .rst(rst), .din(dout), .din_valid(dout_valid), .detect(detect)
  );

  sd_bit_serializer #(.WIDTH(2), .IDLE_BIT(1'b0)) u_w2 (
    .clk(clk), .rst(rst), .load_data(l2_data), .load_valid(l2_valid),
    .load_ready(w2_ready), .dout(w2_dout), .dout_valid(w2_valid),
    .last_bit(w2_last), .busy(w2_busy)
  );

  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [7:0] w, input int k);
`ifdef SD_SER_LSB_FIRST_EN
    return w[k];
`else
    return w[7-k];
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; load_valid = 1'b1; load_data = 8'hA5; l2_valid = 1'b1; l2_data = 2'b01;
    #1;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre: got %b expected 0", load_ready); end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", dout); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", load_ready); end
      checks++; if (busy !== 1'b0 || last_bit !== 1'b0) begin errors++; $display("FAIL reset_busy_last: got %b%b expected 00", busy, last_bit); end
      checks++; if (w2_valid !== 1'b0 || w2_ready !== 1'b0) begin errors++; $display("FAIL reset_w2: got %b%b expected 00", w2_valid, w2_ready); end
    end
    rst = 1'b0; load_valid = 1'b0; l2_valid = 1'b0; m_hist = 2'b00;
    #1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", load_ready); end
    tick;
    checks++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL release_no_accept: got %b%b expected 00", dout_valid, busy); end
  endtask

  task automatic test_single_word;
    logic eb, ed;
    load_data = 8'hA5; load_valid = 1'b1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", load_ready); end
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 0) load_valid = 1'b0;
      eb = exp_bit(8'hA5, k); ed = (m_hist == 2'b10) && eb; m_hist = {m_hist[0], eb};
      checks++; if (dout !== eb) begin errors++; $display("FAIL single_dout[%0d]: got %b expected %b", k, dout, eb); end
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", k, dout_valid); end
      checks++; if (last_bit !== (k == 7)) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", k, last_bit, (k == 7)); end
      checks++; if (detect !== ed) begin errors++; $display("FAIL single_detect[%0d]: got %b expected %b", k, detect, ed); end
    end
    tick;
    checks++; if (dout !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b%b expected 00", dout, dout_valid); end
    checks++; if (busy !== 1'b0 || last_bit !== 1'b0) begin errors++; $display("FAIL single_idle_state: got %b%b expected 00", busy, last_bit); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w [4];
    logic eb, ed;
    w[0] = 8'h05; w[1] = 8'hA0; w[2] = 8'h02; w[3] = 8'h80;
    load_data = w[0]; load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) begin
        tick;
        eb = exp_bit(w[i], k); ed = (m_hist == 2'b10) && eb; m_hist = {m_hist[0], eb};
        checks++; if (dout !== eb || dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_bit[%0d.%0d]: got %b/%b expected %b/1", i, k, dout, dout_valid, eb); end
        checks++; if (last_bit !== (k == 7) || load_ready !== (k == 7)) begin errors++; $display("FAIL b2b_last_ready[%0d.%0d]: got %b%b expected %b%b", i, k, last_bit, load_ready, (k == 7), (k == 7)); end
        checks++; if (detect !== ed) begin errors++; $display("FAIL b2b_detect[%0d.%0d]: got %b expected %b", i, k, detect, ed); end
        if (k == 7) begin
          if (i < 3) load_data = w[i+1];
          else load_valid = 1'b0;
        end
      end
    end
    tick;
    checks++; if (dout_valid !== 1'b0 || dout !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b%b expected 00", dout_valid, dout); end
  endtask

  task automatic test_backpressure;
    logic eb, ed;
    load_data = 8'h3C; load_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 0) load_valid = 1'b0;
      eb = exp_bit(8'h3C, k); ed = (m_hist == 2'b10) && eb; m_hist = {m_hist[0], eb};
      checks++; if (dout !== eb || dout_valid !== 1'b1) begin errors++; $display("FAIL bp_first[%0d]: got %b/%b expected %b/1", k, dout, dout_valid, eb); end
      checks++; if (load_ready !== (k == 7)) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", k, load_ready, (k == 7)); end
      checks++; if (detect !== ed) begin errors++; $display("FAIL bp_detect[%0d]: got %b expected %b", k, detect, ed); end
      if (k == 2) begin load_valid = 1'b1; load_data = 8'hFF; end
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 0) load_valid = 1'b0;
      ed = (m_hist == 2'b10); m_hist = {m_hist[0], 1'b1};
      checks++; if (dout !== 1'b1 || dout_valid !== 1'b1) begin errors++; $display("FAIL bp_second[%0d]: got %b/%b expected 1/1", k, dout, dout_valid); end
      checks++; if (detect !== ed) begin errors++; $display("FAIL bp_detect2[%0d]: got %b expected %b", k, detect, ed); end
    end
    tick;
    checks++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b%b expected 00", dout_valid, busy); end
  endtask

  task automatic test_reset_mid_word;
    load_data = 8'hFF; load_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 0) load_valid = 1'b0;
      checks++; if (dout !== 1'b1 || dout_valid !== 1'b1) begin errors++; $display("FAIL mid_bit[%0d]: got %b/%b expected 1/1", k, dout, dout_valid); end
    end
    rst = 1'b1;
    tick;
    checks++; if (dout !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got %b%b expected 00", dout, dout_valid); end
    checks++; if (busy !== 1'b0 || last_bit !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got %b%b%b expected 000", busy, last_bit, load_ready); end
    rst = 1'b0; m_hist = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (dout_valid !== 1'b0 || dout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_discard[%0d]: got %b%b%b expected 000", k, dout_valid, dout, busy); end
    end
  endtask

  task automatic test_width2;
    logic e0, e1;
`ifdef SD_SER_LSB_FIRST_EN
    e0 = 1'b1; e1 = 1'b0;
`else
    e0 = 1'b0; e1 = 1'b1;
`endif
    l2_data = 2'b01; l2_valid = 1'b1;
    #1;
    checks++; if (w2_ready !== 1'b1) begin errors++; $display("FAIL w2_ready_idle: got %b expected 1", w2_ready); end
    tick;
    l2_valid = 1'b0;
    checks++; if (w2_dout !== e0 || w2_valid !== 1'b1) begin errors++; $display("FAIL w2_bit0: got %b/%b expected %b/1", w2_dout, w2_valid, e0); end
    checks++; if (w2_last !== 1'b0 || w2_ready !== 1'b0) begin errors++; $display("FAIL w2_cycle1: got %b%b expected 00", w2_last, w2_ready); end
    tick;
    checks++; if (w2_dout !== e1 || w2_valid !== 1'b1) begin errors++; $display("FAIL w2_bit1: got %b/%b expected %b/1", w2_dout, w2_valid, e1); end
    checks++; if (w2_last !== 1'b1 || w2_ready !== 1'b1) begin errors++; $display("FAIL w2_cycle2: got %b%b expected 11", w2_last, w2_ready); end
    tick;
    checks++; if (w2_valid !== 1'b0 || w2_dout !== 1'b0 || w2_busy !== 1'b0) begin errors++; $display("FAIL w2_idle: got %b%b%b expected 000", w2_valid, w2_dout, w2_busy); end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_word;
    test_width2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
